i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h68, the 7-bit target device address.
REQ-002 SHALL have port Clk, input, 1 bit: block clock, 4x the SCL rate, sourced from the frequency divider (100 kHz SCL needs a 400 kHz Clk).
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port Start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-005 SHALL have port Rw, input, 1 bit: 0 = register write, 1 = register read; captured with Start.
REQ-006 SHALL have port RegAddr, input, 8 bits: target register, captured with Start.
REQ-007 SHALL have port WrData, input, 8 bits: write byte, captured with Start.
REQ-008 SHALL have port RdData, output, 8 bits: last byte read, held until the next read completes.
REQ-009 SHALL have port Busy, output, 1 bit: transaction in progress.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle pulse at the end of a transaction.
REQ-011 SHALL have port AckErr, output, 1 bit: the target NACKed.
REQ-012 SHALL have port Scl, output, 1 bit: I2C clock, push-pull, with no stretching support.
REQ-013 SHALL have port SdaOe, output, 1 bit: 1 drives SDA low; 0 releases SDA.
REQ-014 SHALL have port SdaIn, input, 1 bit: sampled SDA line.

Function
REQ-015 SHALL run one 2-bit quarter counter q. Every START, bit, RSTART and STOP slot is exactly 4 Clk cycles (q = 0..3).
REQ-016 SHALL use these states: IDLE, START, TXBIT, RXACK, RSTART, RXBIT, TXNACK, STOP, DONE.
REQ-017 IDLE: Scl=1 and SdaOe=0. When Start=1, latch Rw, RegAddr and WrData, and go to START on the next cycle.
REQ-018 SHALL assert Busy from the cycle after Start is accepted until the last STOP cycle inclusive. Start=1 while Busy SHALL be ignored.
REQ-019 START slot: Scl=1 for all of q0-q3; SdaOe=0 for q0-q1 and SdaOe=1 for q2-q3.
REQ-020 Data/ack slot: Scl=0 for q0-q1 and Scl=1 for q2-q3.
REQ-021 In each data/ack slot, SDA SHALL change only at q0 and SdaIn SHALL be sampled at the end of q2.
REQ-022 Bytes SHALL be sent MSB first. Each transmitted byte SHALL be followed by an RXACK slot with SdaOe=0.
REQ-023 Write sequence SHALL be: START, {DEV_ADDR,0}, ACK, RegAddr, ACK, WrData, ACK, STOP.
REQ-024 Read sequence SHALL be: START, {DEV_ADDR,0}, ACK, RegAddr, ACK, RSTART, {DEV_ADDR,1}, ACK, 8 RXBIT slots with SdaOe=0, TXNACK with SdaOe=0, STOP.
REQ-025 RSTART slot: Scl=0 for q0-q1 and Scl=1 for q2-q3; SdaOe=0 for q0-q2 and SdaOe=1 at q3.
REQ-026 STOP slot: SdaOe=1 for q0-q2 and SdaOe=0 at q3; Scl=0 for q0-q1 and Scl=1 for q2-q3.
REQ-027 If SdaIn=1 is sampled in any RXACK slot, the block SHALL set AckErr=1, skip the remaining slots, and proceed directly to STOP.
REQ-028 AckErr SHALL be sticky and SHALL clear only when the next Start is accepted.
REQ-029 RdData SHALL update in the DONE cycle, only for a read with AckErr=0.
REQ-030 DONE SHALL last one cycle with Done=1 and Busy=0, then return to IDLE. A Start present in the DONE cycle SHALL be ignored.
REQ-031 Write latency: Busy=1 for 116 cycles (4 + 27x4 + 4); Done pulses on cycle 117 after acceptance.
REQ-032 Read latency: Busy=1 for 156 cycles (4 + 72 + 4 + 36 + 36 + 4); Done pulses on cycle 157.
REQ-033 The bit counter SHALL count 7 down to 0 within a byte; the byte index SHALL wrap to 0 only at STOP.

Reset
REQ-034 Reset=0 SHALL immediately force IDLE, q=0, Scl=1, SdaOe=0, Busy=0, Done=0, AckErr=0 and RdData=8'h00, including mid-transaction.
REQ-035 After Reset is released, the first Start SHALL begin a fresh START slot. A partial transfer SHALL NOT resume.

Verification
REQ-036 Write, Rw=0, RegAddr=8'h6B, WrData=8'h00, slave ACKs all bytes: bytes on SDA are 8'hD0, 8'h6B, 8'h00; Done at cycle 117; AckErr=0.
REQ-037 Read, Rw=1, RegAddr=8'h75, slave ACKs and returns 8'h68: bytes seen are 8'hD0, 8'h75, 8'hD1; master sends NACK; RdData=8'h68 at Done, cycle 157.
REQ-038 Address NACK, with SdaIn=1 in the first RXACK: STOP follows immediately; Done at cycle 4+36+4+1=45; AckErr=1; RdData unchanged.
REQ-039 Reset pulled low at cycle 50 of a write: Scl=1, SdaOe=0 and Busy=0 in the same cycle; a new Start yields a complete 116-cycle write.
REQ-040 Start held high for the whole write: exactly one transaction occurs; the Start in the DONE cycle is ignored; the next transaction begins only after IDLE resamples Start.
REQ-041 Protocol checker on every run: SDA changes only while Scl=0, except START, RSTART and STOP edges.

Source files
------------

// File: rtl/i2c_master.sv
// Single-master I2C register write/read engine. Every bus slot (START, bit, RSTART, STOP)
// spans four Clk quarters; Scl is push-pull and SdaOe pulls SDA low when set.
module i2c_master #(
  parameter logic [6:0] DEV_ADDR = 7'h68
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Rw,
  input  logic [7:0] RegAddr,
  input  logic [7:0] WrData,
  output logic [7:0] RdData,
  output logic       Busy,
  output logic       Done,
  output logic       AckErr,
  output logic       Scl,
  output logic       SdaOe,
  input  logic       SdaIn
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TXBIT, S_RXACK, S_RSTART, S_RXBIT, S_TXNACK, S_STOP, S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] q_q, q_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic       rw_q, rw_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wr_q, wr_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_q, rd_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] tx_byte;
  logic       slot_end;

  // Byte 2 is the write data for a write, or the read-direction address after RSTART.
  always_comb begin
    unique case (byte_q)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = reg_q;
      default: tx_byte = rw_q ? {DEV_ADDR, 1'b1} : wr_q;
    endcase
  end

  assign slot_end = (q_q == 2'd3);

  // NOTE: every output and next-state value gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rw_d      = rw_q;
    reg_d     = reg_q;
    wr_d      = wr_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    ack_err_d = ack_err_q;
    Scl       = q_q[1];
    SdaOe     = 1'b0;

    if (state_q != S_IDLE && state_q != S_DONE) q_d = q_q + 2'd1;

    unique case (state_q)
      S_IDLE: begin
        Scl = 1'b1;
        q_d = 2'd0;
        if (Start) begin
          state_d   = S_START;
          rw_d      = Rw;
          reg_d     = RegAddr;
          wr_d      = WrData;
          ack_err_d = 1'b0;
          byte_d    = 2'd0;
          bit_d     = 3'd7;
        end
      end
      S_START: begin
        Scl   = 1'b1;
        SdaOe = q_q[1];
        if (slot_end) begin
          state_d = S_TXBIT;
          bit_d   = 3'd7;
        end
      end
      S_TXBIT: begin
        SdaOe = ~tx_byte[bit_q];
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = S_RXACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_RXACK: begin
        if (q_q == 2'd2 && SdaIn) ack_err_d = 1'b1;
        if (slot_end) begin
          bit_d = 3'd7;
          // ack_err_q already reflects this slot's q2 sample by q3.
          if (ack_err_q) begin
            state_d = S_STOP;
          end else begin
            unique case (byte_q)
              2'd0: begin
                state_d = S_TXBIT;
                byte_d  = 2'd1;
              end
              2'd1: begin
                state_d = rw_q ? S_RSTART : S_TXBIT;
                byte_d  = 2'd2;
              end
              default: state_d = rw_q ? S_RXBIT : S_STOP;
            endcase
          end
        end
      end
      S_RSTART: begin
        SdaOe = (q_q == 2'd3);
        if (slot_end) begin
          state_d = S_TXBIT;
          bit_d   = 3'd7;
        end
      end
      S_RXBIT: begin
        if (q_q == 2'd2) rx_d = {rx_q[6:0], SdaIn};
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = S_TXNACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_TXNACK: begin
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        SdaOe  = (q_q != 2'd3);
        byte_d = 2'd0;
        if (slot_end) begin
          state_d = S_DONE;
          if (rw_q && !ack_err_q) rd_d = rx_q;
        end
      end
      S_DONE: begin
        Scl     = 1'b1;
        q_d     = 2'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      q_q       <= 2'd0;
      bit_q     <= 3'd7;
      byte_q    <= 2'd0;
      rw_q      <= 1'b0;
      reg_q     <= 8'h00;
      wr_q      <= 8'h00;
      rx_q      <= 8'h00;
      rd_q      <= 8'h00;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      rw_q      <= rw_d;
      reg_q     <= reg_d;
      wr_q      <= wr_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign Busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign Done   = (state_q == S_DONE);
  assign AckErr = ack_err_q;
  assign RdData = rd_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: bus-level slave model decodes bytes against a
// scoreboard queue and counts START/STOP edges and illegal SDA changes.
module tb_i2c_master;

  localparam logic [6:0] DEV = 7'h68;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Rw = 1'b0;
  logic [7:0] RegAddr = 8'h00;
  logic [7:0] WrData = 8'h00;
  logic [7:0] RdData;
  logic       Busy, Done, AckErr, Scl, SdaOe, SdaIn;

  logic       slave_low = 1'b0;
  logic       nack_mode = 1'b0;
  logic [7:0] rd_val = 8'h00;

  assign SdaIn = ~(SdaOe | slave_low);

  i2c_master #(.DEV_ADDR(DEV)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Rw(Rw), .RegAddr(RegAddr), .WrData(WrData),
    .RdData(RdData), .Busy(Busy), .Done(Done), .AckErr(AckErr), .Scl(Scl), .SdaOe(SdaOe),
    .SdaIn(SdaIn)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] exp_bytes[$];

  // Slave model state, sampled on the falling Clk edge.
  logic       prev_scl = 1'b1;
  logic       prev_line = 1'b1;
  logic       mon_line;
  logic [3:0] bitn = 4'd0;
  logic [7:0] sh = 8'h00;
  logic [7:0] tx_sh = 8'h00;
  logic       first_byte = 1'b0;
  logic       slave_tx = 1'b0;
  int         n_start = 0;
  int         n_stop = 0;
  int         n_viol = 0;

  always @(negedge Clk) begin
    mon_line = ~(SdaOe | slave_low);
    if (!Reset) begin
      bitn       = 4'd0;
      slave_tx   = 1'b0;
      first_byte = 1'b0;
      slave_low  = 1'b0;
      prev_scl   = 1'b1;
      prev_line  = 1'b1;
    end else begin
      if (prev_scl && Scl && mon_line != prev_line) begin
        if (!mon_line) begin
          n_start++;
          bitn       = 4'd0;
          first_byte = 1'b1;
          slave_tx   = 1'b0;
        end else begin
          n_stop++;
        end
      end else if (!prev_scl && Scl && mon_line != prev_line) begin
        n_viol++;
      end

      if (!prev_scl && Scl) begin
        if (bitn < 4'd8) begin
          sh   = {sh[6:0], mon_line};
          bitn = bitn + 4'd1;
        end else begin
          if (!slave_tx) begin
            if (exp_bytes.size() > 0) check("tx_byte", {24'h0, sh}, {24'h0, exp_bytes.pop_front()});
            else check("byte_pending", exp_bytes.size(), 1);
          end else begin
            check("master_nack", {31'h0, mon_line}, 1);
          end
          slave_tx   = !slave_tx && first_byte && sh[0];
          tx_sh      = rd_val;
          first_byte = 1'b0;
          bitn       = 4'd0;
        end
      end

      if (prev_scl && !Scl) begin
        if (bitn == 4'd8) begin
          slave_low = !slave_tx && !nack_mode;
        end else if (slave_tx) begin
          slave_low = ~tx_sh[7];
          tx_sh     = {tx_sh[6:0], 1'b0};
        end else begin
          slave_low = 1'b0;
        end
      end
      prev_scl  = Scl;
      prev_line = ~(SdaOe | slave_low);
    end
  end

  task automatic run_txn(input logic rw, input logic [7:0] ra, input logic [7:0] wd,
                         input logic [7:0] rv, input logic nack, input logic hold,
                         input int exp_done, input logic exp_err, input logic [7:0] exp_rd,
                         input int exp_starts);
    int  n;
    int  busy_n;
    logic got;
    @(negedge Clk);
    Rw = rw; RegAddr = ra; WrData = wd; rd_val = rv; nack_mode = nack; Start = 1'b1;
    n_start = 0; n_stop = 0; n_viol = 0;
    exp_bytes.push_back({DEV, 1'b0});
    if (!nack) begin
      exp_bytes.push_back(ra);
      exp_bytes.push_back(rw ? {DEV, 1'b1} : wd);
    end
    n = 0; busy_n = 0; got = 1'b0;
    while (n < 400 && !got) begin
      @(negedge Clk);
      n++;
      if (n == 1) begin
        check("ackerr_clear", {31'h0, AckErr}, 0);
        if (hold) begin
          RegAddr = ~ra;
          WrData  = ~wd;
        end else begin
          Start = 1'b0;
        end
      end
      if (Busy) busy_n++;
      if (Done) got = 1'b1;
    end
    check("done_cycle", n, exp_done);
    check("busy_cycles", busy_n, exp_done - 1);
    check("busy_at_done", {31'h0, Busy}, 0);
    check("ackerr", {31'h0, AckErr}, {31'h0, exp_err});
    check("rddata", {24'h0, RdData}, {24'h0, exp_rd});
    check("starts", n_start, exp_starts);
    check("stops", n_stop, 1);
    check("sda_viol", n_viol, 0);
    check("bytes_left", exp_bytes.size(), 0);
    if (hold) begin
      @(negedge Clk);
      check("held_idle_busy", {31'h0, Busy}, 0);
      check("held_idle_done", {31'h0, Done}, 0);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      check("held_no_rerun", {31'h0, Busy}, 0);
    end
    exp_bytes.delete();
    nack_mode = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge Clk);
    check("rst_scl", {31'h0, Scl}, 1);
    check("rst_sdaoe", {31'h0, SdaOe}, 0);
    check("rst_busy", {31'h0, Busy}, 0);
    check("rst_done", {31'h0, Done}, 0);
    check("rst_ackerr", {31'h0, AckErr}, 0);
    check("rst_rddata", {24'h0, RdData}, 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    run_txn(1'b0, 8'h6B, 8'h00, 8'h00, 1'b0, 1'b0, 117, 1'b0, 8'h00, 1);
    run_txn(1'b1, 8'h75, 8'h00, 8'h68, 1'b0, 1'b0, 157, 1'b0, 8'h68, 2);
    run_txn(1'b1, 8'h75, 8'h00, 8'h55, 1'b1, 1'b0, 45,  1'b1, 8'h68, 1);
    run_txn(1'b0, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b0, 117, 1'b0, 8'h68, 1);

    // Abort a write at cycle 50 with an asynchronous reset.
    @(negedge Clk);
    Rw = 1'b0; RegAddr = 8'h6B; WrData = 8'h00; Start = 1'b1;
    exp_bytes.push_back({DEV, 1'b0});
    n = 0;
    while (n < 50) begin
      @(negedge Clk);
      n++;
      Start = 1'b0;
    end
    check("mid_busy", {31'h0, Busy}, 1);
    #2 Reset = 1'b0;
    #1;
    check("abort_scl", {31'h0, Scl}, 1);
    check("abort_sdaoe", {31'h0, SdaOe}, 0);
    check("abort_busy", {31'h0, Busy}, 0);
    check("abort_rddata", {24'h0, RdData}, 0);
    check("abort_bytes", exp_bytes.size(), 0);
    exp_bytes.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    run_txn(1'b0, 8'h6B, 8'h00, 8'h00, 1'b0, 1'b0, 117, 1'b0, 8'h00, 1);

    run_txn(1'b0, 8'h1E, 8'hC3, 8'h00, 1'b0, 1'b1, 117, 1'b0, 8'h00, 1);
    run_txn(1'b1, 8'h0F, 8'h00, 8'h9A, 1'b0, 1'b0, 157, 1'b0, 8'h9A, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
